// File: rtl/tia_video_pkg.sv
// tia_video_pkg: shared video types and constants for the TIA-to-HDMI path.
// Holds the source line geometry defaults, the border color, the 7-bit
// TIA color type and the 720x480 raster constants used by the HDMI stage.
package tia_video_pkg;

    // Source line geometry defaults
    localparam int SRC_WIDTH_DEF = 160;
    localparam int SRC_LINES_DEF = 192;

    // Output raster shared with the HDMI stage
    localparam int RASTER_H_ACTIVE = 720;
    localparam int RASTER_V_ACTIVE = 480;
    localparam int RASTER_H_TOTAL  = 858;

    // Color outside the scaled window
    localparam logic [6:0] BORDER_COLOR_DEF = 7'h00;

    // TIA color: {hue[6:3], lum[2:0]}
    localparam int HUE_W = 4;
    localparam int LUM_W = 3;

    typedef struct packed {
        logic [HUE_W-1:0] hue;
        logic [LUM_W-1:0] lum;
    } color_t;

    // Read-side state: whether the pixel being fetched lies inside the window
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_t;

    // Same hue, luminance halved (used for the darker scanline row)
    function automatic color_t dim_color(input color_t c);
        color_t r;
        r.hue = c.hue;
        r.lum = c.lum >> 1;
        return r;
    endfunction

endpackage

// File: rtl/tia_line_doubler_line_ram.sv
// line_ram: two line banks in one array with one write port and one
// synchronous read port. The bank select is the address MSB; each bank
// occupies a power-of-two slot so the low bits are the pixel index.
module line_ram #(
    parameter int DATA_W = 7,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_reg;

    // Write port and registered read port (read returns old data on collision)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/tia_line_doubler.sv
// tia_line_doubler: ping-pong line buffer between the TIA pixel stream and
// the HDMI output stage. Captures SRC_WIDTH-pixel source lines into one bank
// while the other bank is replayed H_SCALE x V_SCALE into a window of the
// raster. Pipeline from hpos/vpos to color is 2 cycles (RAM read + output
// register), so window decisions are made on hpos+2.
// Optional build macro: TIA_SCANLINES_EN -- halves luminance on the last
// repeat row of each source line.
module tia_line_doubler
    import tia_video_pkg::*;
#(
    parameter int         SRC_WIDTH    = SRC_WIDTH_DEF,
    parameter int         SRC_LINES    = SRC_LINES_DEF,
    parameter int         H_SCALE      = 4,
    parameter int         V_SCALE      = 2,
    parameter int         H_OFFSET     = (RASTER_H_ACTIVE - SRC_WIDTH_DEF * 4) / 2,
    parameter int         V_OFFSET     = (RASTER_V_ACTIVE - SRC_LINES_DEF * 2) / 2,
    parameter int         H_TOTAL      = RASTER_H_TOTAL,
    parameter logic [6:0] BORDER_COLOR = BORDER_COLOR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [6:0] pix_color,
    input  logic       line_start,
    input  logic       frame_start,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic [6:0] color,
    output logic       underrun,
    output logic       overrun
);

    localparam int PTR_W  = $clog2(SRC_WIDTH + 1);
    localparam int ADDR_W = PTR_W + 1;
    localparam int HS_W   = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int VS_W   = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(SRC_WIDTH - 1);
    localparam logic [PTR_W-1:0] PTR_END   = PTR_W'(SRC_WIDTH);
    localparam logic [HS_W-1:0]  HS_LAST   = HS_W'(H_SCALE - 1);
    localparam logic [VS_W-1:0]  VS_LAST   = VS_W'(V_SCALE - 1);
    localparam logic [9:0]       H_START   = 10'(H_OFFSET);
    localparam logic [9:0]       H_STOP    = 10'(H_OFFSET + SRC_WIDTH * H_SCALE);
    localparam logic [9:0]       V_START   = 10'(V_OFFSET);
    localparam logic [9:0]       V_STOP    = 10'(V_OFFSET + SRC_LINES * V_SCALE);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [10:0]      H_TOTAL_X = 11'(H_TOTAL);

    // State registers
    logic [PTR_W-1:0] wr_ptr_reg,   wr_ptr_next;
    logic             wr_bank_reg,  wr_bank_next;
    logic [1:0]       full_reg,     full_next;
    logic             underrun_reg, underrun_next;
    logic             overrun_reg,  overrun_next;
    logic [PTR_W-1:0] rd_addr_reg,  rd_addr_next;
    logic [HS_W-1:0]  h_sub_reg,    h_sub_next;
    logic [VS_W-1:0]  v_sub_reg,    v_sub_next;
    rd_state_t        rd_state_reg, rd_state_next;
    logic [6:0]       color_reg,    color_next;
`ifdef TIA_SCANLINES_EN
    logic             scan_reg,     scan_next;
`endif

    // Write-side decode
    logic             restart;
    logic [PTR_W-1:0] wr_ptr_eff;
    logic [1:0]       full_eff;
    logic             wr_en;
    logic             line_done;
    logic             wr_full;
    logic             rd_bank;

    // Read-side decode
    logic [10:0]      hsum;
    logic [9:0]       hpos_la;
    logic             h_in;
    logic             row_active;
    logic             in_window;
    logic             at_left;
    logic [HS_W-1:0]  h_sub_cur;
    logic [PTR_W-1:0] rd_addr_cur;
    logic [VS_W-1:0]  v_sub_cur;
    logic             swap_point;
    logic             swap_ok;

    logic [ADDR_W-1:0] ram_wr_addr;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [6:0]        ram_q;
    color_t            rd_color;

    // line_start / frame_start take effect in the same cycle as a coincident pixel
    assign restart    = line_start | frame_start;
    assign wr_ptr_eff = restart ? '0 : wr_ptr_reg;
    assign full_eff   = frame_start ? 2'b00 : full_reg;
    assign wr_en      = pix_valid && (wr_ptr_eff < PTR_END);
    assign line_done  = wr_en && (wr_ptr_eff == PTR_LAST);
    assign wr_full    = full_eff[wr_bank_reg];
    assign rd_bank    = ~wr_bank_reg;

    // Look two columns ahead to cover the RAM and output register stages
    assign hsum       = {1'b0, hpos} + 11'd2;
    assign hpos_la    = (hsum >= H_TOTAL_X) ? 10'(hsum - H_TOTAL_X) : 10'(hsum);
    assign h_in       = (hpos_la >= H_START) && (hpos_la < H_STOP);
    assign row_active = (vpos >= V_START) && (vpos < V_STOP);
    assign in_window  = h_in && row_active;
    assign at_left    = (hpos_la == H_START);
    assign h_sub_cur  = at_left ? '0 : h_sub_reg;
    assign rd_addr_cur = at_left ? '0 : rd_addr_reg;
    assign v_sub_cur  = (vpos == V_START) ? '0 : v_sub_reg;

    // A line completing on the swap cycle is forwarded so the swap still succeeds
    assign swap_point = (hpos == H_LAST) && row_active && (v_sub_cur == VS_LAST);
    assign swap_ok    = swap_point && (wr_full || line_done);

    assign ram_wr_addr = {wr_bank_reg, wr_ptr_eff};
    assign ram_rd_addr = {rd_bank, rd_addr_cur};

    line_ram #(
        .DATA_W (7),
        .ADDR_W (ADDR_W)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (pix_color),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    assign rd_color = ram_q;

    // Write pointer, bank-full flags, bank exchange and sticky status
    always_comb begin
        wr_ptr_next   = wr_ptr_eff;
        full_next     = full_eff;
        wr_bank_next  = wr_bank_reg;
        underrun_next = underrun_reg | (swap_point & ~swap_ok);
        overrun_next  = overrun_reg | (line_done & wr_full);
        if (wr_en) begin
            wr_ptr_next = wr_ptr_eff + PTR_W'(1);
        end
        if (line_done) begin
            full_next[wr_bank_reg] = 1'b1;
        end
        if (swap_ok) begin
            full_next[rd_bank] = 1'b0;
            wr_bank_next       = ~wr_bank_reg;
            wr_ptr_next        = '0;
        end
    end

    // Horizontal replay counters and vertical repeat counter
    always_comb begin
        h_sub_next   = h_sub_reg;
        rd_addr_next = rd_addr_reg;
        v_sub_next   = v_sub_cur;
        if (in_window) begin
            if (h_sub_cur == HS_LAST) begin
                h_sub_next   = '0;
                rd_addr_next = rd_addr_cur + PTR_W'(1);
            end else begin
                h_sub_next   = h_sub_cur + HS_W'(1);
                rd_addr_next = rd_addr_cur;
            end
        end
        if (row_active && (hpos == H_LAST)) begin
            v_sub_next = (v_sub_cur == VS_LAST) ? '0 : v_sub_cur + VS_W'(1);
        end
    end

    // Read FSM: tracks whether the fetched pixel is in the window, selects output color
    always_comb begin
        rd_state_next = RD_IDLE;
        color_next    = BORDER_COLOR;
        if (in_window) begin
            rd_state_next = RD_ACTIVE;
        end
        case (rd_state_reg)
            RD_ACTIVE: begin
`ifdef TIA_SCANLINES_EN
                color_next = scan_reg ? dim_color(rd_color) : rd_color;
`else
                color_next = rd_color;
`endif
            end
            default: color_next = BORDER_COLOR;
        endcase
    end

`ifdef TIA_SCANLINES_EN
    assign scan_next = (v_sub_cur == VS_LAST);
`endif

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            wr_bank_reg  <= 1'b0;
            full_reg     <= 2'b00;
            underrun_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            rd_addr_reg  <= '0;
            h_sub_reg    <= '0;
            v_sub_reg    <= '0;
            rd_state_reg <= RD_IDLE;
            color_reg    <= BORDER_COLOR;
`ifdef TIA_SCANLINES_EN
            scan_reg     <= 1'b0;
`endif
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            wr_bank_reg  <= wr_bank_next;
            full_reg     <= full_next;
            underrun_reg <= underrun_next;
            overrun_reg  <= overrun_next;
            rd_addr_reg  <= rd_addr_next;
            h_sub_reg    <= h_sub_next;
            v_sub_reg    <= v_sub_next;
            rd_state_reg <= rd_state_next;
            color_reg    <= color_next;
`ifdef TIA_SCANLINES_EN
            scan_reg     <= scan_next;
`endif
        end
    end

    assign color    = color_reg;
    assign underrun = underrun_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_tia_line_doubler.sv
// tb_tia_line_doubler: directed bench for tia_line_doubler. Drives the beam
// counters row by row, writes source lines, and checks color and the sticky
// flags at chosen columns against hand-derived expectations.
module tb_tia_line_doubler;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_valid;
    logic [6:0] pix_color;
    logic       line_start;
    logic       frame_start;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [6:0] color;
    logic       underrun;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tia_line_doubler dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hpos        (hpos),
        .vpos        (vpos),
        .color       (color),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %-14s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %-14s got=0x%0h", tag, got);
        end
    endtask

    // Source line contents: A = i, B = i+32, C = 159-i (all mod 128)
    function automatic logic [6:0] line_px(input int sel, input int i);
        case (sel)
            0:       return 7'(i);
            1:       return 7'(i + 32);
            default: return 7'(159 - i);
        endcase
    endfunction

    function automatic logic [6:0] shade(input logic [6:0] c, input bit scan_row);
        bit dim_on;
`ifdef TIA_SCANLINES_EN
        dim_on = 1'b1;
`else
        dim_on = 1'b0;
`endif
        if (scan_row && dim_on) return {c[6:3], 1'b0, c[2:1]};
        return c;
    endfunction

    // Expected color at column h of row v when line sel is on display
    function automatic logic [6:0] exp_color(input int h, input int v, input int sel);
        if (h < 40 || h >= 680 || v < 48 || v >= 432) return 7'h00;
        return shade(line_px(sel, (h - 40) / 4), ((v - 48) % 2) == 1);
    endfunction

    function automatic bit is_probe(input int h);
        return (h == 39 || h == 40 || h == 43 || h == 44 || h == 47 ||
                h == 388 || h == 676 || h == 679 || h == 680);
    endfunction

    task automatic idle_inputs();
        pix_valid   = 1'b0;
        pix_color   = 7'h00;
        line_start  = 1'b0;
        frame_start = 1'b0;
    endtask

    // Write one source line on an inactive raster position, plus optional extra strobes
    task automatic write_line(input int sel, input bit use_frame, input int extra);
        hpos = 10'd0;
        vpos = 10'd0;
        for (int i = 0; i < 160 + extra; i++) begin
            pix_valid   = 1'b1;
            pix_color   = (i < 160) ? line_px(sel, i) : 7'h7F;
            line_start  = (i == 0) && !use_frame;
            frame_start = (i == 0) && use_frame;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // Run one raster row; optionally write line wsel starting at column ws and
    // check color at probe columns against line dsel
    task automatic run_row(input int v, input int ws, input int wsel, input bit chk, input int dsel);
        for (int h = 0; h < 858; h++) begin
            hpos = 10'(h);
            vpos = 10'(v);
            idle_inputs();
            if (ws >= 0 && h >= ws && h < ws + 160) begin
                pix_valid  = 1'b1;
                pix_color  = line_px(wsel, h - ws);
                line_start = (h == ws);
            end
            if (chk && is_probe(h))
                check($sformatf("r%0d_h%0d", v, h), 32'(color), 32'(exp_color(h, v, dsel)));
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        hpos  = 10'd0;
        vpos  = 10'd0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_color", 32'(color), 32'h00);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_wr_ptr", 32'(dut.wr_ptr_reg), 32'h0);
        reset = 1'b0;

        // Line A, first pixel coinciding with frame_start
        write_line(0, 1'b1, 0);
        // First pass through rows 48-49 swaps line A onto the display
        run_row(48, -1, 0, 1'b0, 0);
        run_row(49, -1, 0, 1'b0, 0);
        check("prime_underrun", 32'(underrun), 32'h0);

        run_row(48, -1, 0, 1'b1, 0);
        run_row(49, -1, 0, 1'b1, 0);
        check("underrun_set", 32'(underrun), 32'h1);
        run_row(50, -1, 0, 1'b1, 0);
        run_row(51, -1, 0, 1'b1, 0);

        // Two completions into a full write bank; extra strobes must be ignored
        write_line(1, 1'b0, 0);
        check("overrun_clr", 32'(overrun), 32'h0);
        write_line(2, 1'b0, 4);
        check("overrun_set", 32'(overrun), 32'h1);
        run_row(52, -1, 0, 1'b0, 0);
        run_row(53, -1, 0, 1'b0, 0);
        run_row(54, -1, 0, 1'b1, 2);

        // Reset during source pixel 80 while a window row is on display
        vpos = 10'd55;
        for (int h = 0; h <= 120; h++) begin
            hpos = 10'(h);
            idle_inputs();
            if (h >= 40) begin
                pix_valid  = 1'b1;
                pix_color  = line_px(0, h - 40);
                line_start = (h == 40);
            end
            if (h == 120) begin
                check("pre_rst_color", 32'(color), 32'(exp_color(120, 55, 2)));
                reset = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("mid_rst_color", 32'(color), 32'h00);
        check("mid_rst_under", 32'(underrun), 32'h0);
        check("mid_rst_over", 32'(overrun), 32'h0);
        check("mid_rst_wr_ptr", 32'(dut.wr_ptr_reg), 32'h0);
        reset = 1'b0;
        idle_inputs();

        // Line B completes exactly at hpos 857 of row 49 (the swap point)
        run_row(48, -1, 0, 1'b0, 0);
        run_row(49, 698, 1, 1'b0, 0);
        check("sim_underrun", 32'(underrun), 32'h0);
        check("sim_overrun", 32'(overrun), 32'h0);
        run_row(50, -1, 0, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
